// File: rtl/exp_golomb_decoder_if.sv
// Link between the Exp-Golomb decoder, the barrel shifter that feeds it and
// the syntax-element requester.
//
// Shifter side:
//   ready        shifter window valid
//   bitstream    16-bit left-aligned window; bit 15 is the next unconsumed bit
//   shift_en_c   consume num_shift_c bits (combinational)
//   num_shift_c  bits to consume, 1..16 (combinational)
// Request/result side:
//   start        request one decode
//   is_signed    0 = ue(v), 1 = se(v), sampled with start
//   trunc_one    te(v) range-1 decode, sampled with start (EG_TRUNC_EN only)
//   busy         decoder not idle
//   valid        one-cycle result strobe
//   value        32-bit result, held until the next valid
//   error        one-cycle prefix over-length strobe
//
// Optional feature macro: EG_TRUNC_EN adds trunc_one.
interface exp_golomb_decoder_if;
    logic        ready;
    logic [15:0] bitstream;
    logic        start;
    logic        is_signed;
`ifdef EG_TRUNC_EN
    logic        trunc_one;
`endif
    logic        shift_en_c;
    logic [4:0]  num_shift_c;
    logic        busy;
    logic        valid;
    logic [31:0] value;
    logic        error;

`ifdef EG_TRUNC_EN
    // Decoder view
    modport slave (
        input  ready, bitstream, start, is_signed, trunc_one,
        output shift_en_c, num_shift_c, busy, valid, value, error
    );
    // Shifter/requester view
    modport master (
        output ready, bitstream, start, is_signed, trunc_one,
        input  shift_en_c, num_shift_c, busy, valid, value, error
    );
`else
    // Decoder view
    modport slave (
        input  ready, bitstream, start, is_signed,
        output shift_en_c, num_shift_c, busy, valid, value, error
    );
    // Shifter/requester view
    modport master (
        output ready, bitstream, start, is_signed,
        input  shift_en_c, num_shift_c, busy, valid, value, error
    );
`endif
endinterface

// File: rtl/exp_golomb_decoder.sv
// Exp-Golomb ue(v)/se(v) decoder sitting behind the slice-data barrel shifter.
// Counts the zero prefix (possibly across several all-zero windows), consumes
// the terminating 1, gathers the info suffix 16 bits at a time and returns
// codeNum (or its signed mapping) with a one-cycle valid strobe. A prefix
// longer than MAX_LZ raises a one-cycle error and leaves those bits unconsumed.
//
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_enable  module enable; low forces IDLE and clears state
//   io_bus    exp_golomb_decoder_if.slave (shifter window/shift, request/result)
//
// Optional feature macro: EG_TRUNC_EN enables te(v) range-1 decodes via
// io_bus.trunc_one.
module exp_golomb_decoder #(
    parameter int unsigned MAX_LZ = 31
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    exp_golomb_decoder_if.slave        io_bus
);

    localparam int unsigned WIN_W = 16;
    localparam int unsigned LZ_W  = 7;
    localparam int unsigned NS_W  = 5;
    localparam int unsigned VAL_W = 32;
    localparam int unsigned EXT_W = 33;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_SUFFIX,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [LZ_W-1:0]    r_lz_cnt;
    logic [LZ_W-1:0]    r_remaining;
    logic [LZ_W-1:0]    r_code_len;
    logic [VAL_W-1:0]   r_info;
    logic               r_signed;
    logic               r_trunc;
    logic [VAL_W-1:0]   r_value;
    logic               r_valid;
    logic               r_error;
    logic               r_busy;

    logic [LZ_W-1:0]    w_lz_nxt;
    logic [LZ_W-1:0]    w_rem_nxt;
    logic [VAL_W-1:0]   w_info_nxt;
    logic               w_shift_en_c;
    logic [NS_W-1:0]    w_num_shift_c;

    logic               w_start_acc;
    logic               w_trunc_req;
    logic               w_win_zero;
    logic [3:0]         w_lzc;
    logic [LZ_W-1:0]    w_len;
    logic               w_zero_over;
    logic               w_len_over;
    logic [NS_W-1:0]    w_suffix_n;
    logic               w_suffix_last;
    logic [LZ_W-1:0]    w_len_sel;
    logic [EXT_W-1:0]   w_code33;
    logic [EXT_W-1:0]   w_se33;
    logic [VAL_W-1:0]   w_result;

    // Leading-zero count of a non-zero window (0..15)
    function automatic logic [3:0] f_lzc(input logic [WIN_W-1:0] v);
        logic [3:0] cnt;
        logic       found;
        cnt   = 4'd0;
        found = 1'b0;
        for (int i = WIN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 4'd1;
            end
        end
        return cnt;
    endfunction

`ifdef EG_TRUNC_EN
    assign w_trunc_req = io_bus.trunc_one;
`else
    assign w_trunc_req = 1'b0;
`endif

    // Window decode shared by next-state and output logic
    assign w_start_acc   = (r_state == S_IDLE) && io_bus.start && io_bus.ready;
    assign w_win_zero    = (io_bus.bitstream == '0);
    assign w_lzc         = f_lzc(io_bus.bitstream);
    assign w_len         = r_lz_cnt + LZ_W'(w_lzc);
    assign w_zero_over   = (r_lz_cnt + LZ_W'(WIN_W)) > LZ_W'(MAX_LZ);
    assign w_len_over    = w_len > LZ_W'(MAX_LZ);
    assign w_suffix_last = (r_remaining <= LZ_W'(WIN_W));
    assign w_suffix_n    = w_suffix_last ? NS_W'(r_remaining) : NS_W'(WIN_W);

    // Result mapping; code length comes straight from the prefix when L == 0
    assign w_len_sel = (r_state == S_PREFIX) ? w_len : r_code_len;
    assign w_code33  = ((EXT_W'(1) << w_len_sel) - EXT_W'(1)) + EXT_W'(w_info_nxt);
    assign w_se33    = w_code33[0] ? ((w_code33 + EXT_W'(1)) >> 1)
                                   : (EXT_W'(0) - (w_code33 >> 1));

    always_comb begin
        w_result = r_signed ? VAL_W'(w_se33) : VAL_W'(w_code33);
        if (r_trunc) w_result = {31'd0, ~io_bus.bitstream[WIN_W-1]};
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) r_state <= S_IDLE;
        else                      r_state <= w_state_nxt;
    end

    // Next-state logic; shifter-facing states hold while the window is not ready
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_nxt = S_PREFIX;
            end
            S_PREFIX: begin
                if (io_bus.ready) begin
                    if (r_trunc) begin
                        w_state_nxt = S_DONE;
                    end else if (w_win_zero) begin
                        if (w_zero_over) w_state_nxt = S_ERROR;
                    end else if (w_len_over) begin
                        w_state_nxt = S_ERROR;
                    end else if (w_len == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SUFFIX;
                    end
                end
            end
            S_SUFFIX: begin
                if (io_bus.ready && w_suffix_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: shift request to the shifter plus datapath next values
    always_comb begin
        w_shift_en_c  = 1'b0;
        w_num_shift_c = '0;
        w_lz_nxt      = r_lz_cnt;
        w_rem_nxt     = r_remaining;
        w_info_nxt    = r_info;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_lz_nxt   = '0;
                    w_rem_nxt  = '0;
                    w_info_nxt = '0;
                end
            end
            S_PREFIX: begin
                if (io_bus.ready) begin
                    if (r_trunc) begin
                        w_shift_en_c  = 1'b1;
                        w_num_shift_c = NS_W'(1);
                    end else if (w_win_zero) begin
                        if (!w_zero_over) begin
                            w_shift_en_c  = 1'b1;
                            w_num_shift_c = NS_W'(WIN_W);
                            w_lz_nxt      = r_lz_cnt + LZ_W'(WIN_W);
                        end
                    end else if (!w_len_over) begin
                        // Consume the zeros plus the terminating 1
                        w_shift_en_c  = 1'b1;
                        w_num_shift_c = NS_W'(w_lzc) + NS_W'(1);
                        w_rem_nxt     = w_len;
                    end
                end
            end
            S_SUFFIX: begin
                if (io_bus.ready) begin
                    w_shift_en_c  = 1'b1;
                    w_num_shift_c = w_suffix_n;
                    w_info_nxt    = (r_info << w_suffix_n)
                                  | (VAL_W'(io_bus.bitstream) >> (NS_W'(WIN_W) - w_suffix_n));
                    w_rem_nxt     = r_remaining - LZ_W'(w_suffix_n);
                end
            end
            default: ;
        endcase
        // Never consume bits while being reset or disabled
        if (i_reset || !i_enable) begin
            w_shift_en_c  = 1'b0;
            w_num_shift_c = '0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            r_lz_cnt    <= '0;
            r_remaining <= '0;
            r_code_len  <= '0;
            r_info      <= '0;
            r_signed    <= 1'b0;
            r_trunc     <= 1'b0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_lz_cnt    <= w_lz_nxt;
            r_remaining <= w_rem_nxt;
            r_info      <= w_info_nxt;
            if (w_start_acc) begin
                r_signed <= io_bus.is_signed;
                r_trunc  <= w_trunc_req;
            end
            if (r_state == S_PREFIX && w_state_nxt == S_SUFFIX) r_code_len <= w_len;
            if (w_state_nxt == S_DONE) r_value <= w_result;
            r_valid <= (w_state_nxt == S_DONE);
            r_error <= (w_state_nxt == S_ERROR);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign io_bus.shift_en_c  = w_shift_en_c;
    assign io_bus.num_shift_c = w_num_shift_c;
    assign io_bus.busy        = r_busy;
    assign io_bus.valid       = r_valid;
    assign io_bus.value       = r_value;
    assign io_bus.error       = r_error;

endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Directed bench for exp_golomb_decoder with a registered barrel-shifter model.
module tb_exp_golomb_decoder;

    logic clk;
    logic rst;
    logic en;

    int n_checks;
    int n_errors;

    exp_golomb_decoder_if eg();

    exp_golomb_decoder #(.MAX_LZ(31)) u_dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_enable (en),
        .io_bus   (eg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter model: window updates on the cycle after a shift
    logic [127:0] tb_stream;
    int           tb_base;
    int           consumed;
    logic [127:0] w_sh;

    initial consumed = 0;
    always @(posedge clk) begin
        if (eg.shift_en_c) consumed <= consumed + int'(eg.num_shift_c);
    end
    assign w_sh         = tb_stream << (consumed - tb_base);
    assign eg.bitstream = w_sh[127:112];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] s);
        tb_stream = s;
        tb_base   = consumed;
    endtask

    // One decode: returns latency (cycles after Start sampled), packed shift list
    task automatic run(input logic sgn, input int stall_at, input int stall_len,
                       output int lat, output logic [31:0] shc,
                       output logic got_v, output logic got_e, output int stall_sh);
        shc = 0; lat = 0; got_v = 1'b0; got_e = 1'b0; stall_sh = 0;
        eg.start = 1'b1;
        eg.is_signed = sgn;
        step();
        eg.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            eg.ready = !(c >= stall_at && c < stall_at + stall_len);
            #1;
            if (eg.shift_en_c) begin
                shc = (shc << 5) | 32'(eg.num_shift_c);
                if (!eg.ready) stall_sh++;
            end
            if (eg.valid || eg.error) begin
                lat   = c;
                got_v = eg.valid;
                got_e = eg.error;
                break;
            end
            step();
        end
        eg.ready = 1'b1;
        step();
    endtask

    task automatic dec(input string tag, input logic [127:0] s, input logic sgn,
                       input int stall_at, input int stall_len,
                       input int exp_lat, input logic [31:0] exp_shc,
                       input logic exp_v, input logic [31:0] exp_val);
        int         lat;
        logic [31:0] shc;
        logic       gv, ge;
        int         ss;
        load(s);
        run(sgn, stall_at, stall_len, lat, shc, gv, ge, ss);
        chk_eq({tag, "_valid"}, 32'(gv), 32'(exp_v));
        chk_eq({tag, "_error"}, 32'(ge), 32'(!exp_v));
        chk_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk_eq({tag, "_shifts"}, shc, exp_shc);
        chk_eq({tag, "_value"}, eg.value, exp_val);
        chk_eq({tag, "_stallsh"}, 32'(ss), 32'd0);
        chk_eq({tag, "_busy_after"}, 32'(eg.busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        en  = 1'b1;
        eg.ready = 1'b1;
        eg.start = 1'b0;
        eg.is_signed = 1'b0;
`ifdef EG_TRUNC_EN
        eg.trunc_one = 1'b0;
`endif
        load({16'h8000, 112'd0});
        step();
        step();
        chk_eq("rst_busy", 32'(eg.busy), 32'd0);
        chk_eq("rst_valid", 32'(eg.valid), 32'd0);
        chk_eq("rst_error", 32'(eg.error), 32'd0);
        chk_eq("rst_value", eg.value, 32'd0);
        chk_eq("rst_shift_en", 32'(eg.shift_en_c), 32'd0);
        rst = 1'b0;
        step();

        // tag, stream, signed, stall_at, stall_len, latency, shifts, valid, value
        dec("ue0",      {16'h8000, 112'd0},                    1'b0, 0, 0, 2, 32'd1,                      1'b1, 32'd0);
        dec("ue6",      {16'h3C00, 112'd0},                    1'b0, 0, 0, 3, 32'({5'd3, 5'd2}),          1'b1, 32'd6);
        dec("se6",      {16'h3C00, 112'd0},                    1'b1, 0, 0, 3, 32'({5'd3, 5'd2}),          1'b1, 32'hFFFFFFFD);
        dec("se1",      {3'b010, 125'd0},                      1'b1, 0, 0, 3, 32'({5'd2, 5'd1}),          1'b1, 32'd1);
        dec("se2",      {3'b011, 125'd0},                      1'b1, 0, 0, 3, 32'({5'd2, 5'd1}),          1'b1, 32'hFFFFFFFF);
        dec("ue4",      {5'b00101, 123'd0},                    1'b0, 0, 0, 3, 32'({5'd3, 5'd2}),          1'b1, 32'd4);
        dec("ue_l20",   {20'd0, 1'b1, 20'hFFFFF, 87'd0},       1'b0, 0, 0, 5, 32'({5'd16, 5'd5, 5'd16, 5'd4}),  1'b1, 32'd2097150);
        dec("ue_l31",   {31'd0, 1'b1, 31'h7FFFFFFF, 65'd0},    1'b0, 0, 0, 5, 32'({5'd16, 5'd16, 5'd16, 5'd15}), 1'b1, 32'hFFFFFFFE);
        dec("se_l31",   {31'd0, 1'b1, 31'h7FFFFFFF, 65'd0},    1'b1, 0, 0, 5, 32'({5'd16, 5'd16, 5'd16, 5'd15}), 1'b1, 32'h80000001);
        // Over-length prefix: error, value keeps the previous result
        dec("err_l32",  128'd0,                                1'b0, 0, 0, 3, 32'd16,                     1'b0, 32'h80000001);
        dec("stall",    {16'h3C00, 112'd0},                    1'b0, 2, 3, 6, 32'({5'd3, 5'd2}),          1'b1, 32'd6);

        // Reset during SUFFIX aborts the decode
        load({16'h3C00, 112'd0});
        eg.start = 1'b1;
        eg.is_signed = 1'b0;
        step();
        eg.start = 1'b0;
        step();
        chk_eq("rs_mid_busy", 32'(eg.busy), 32'd1);
        chk_eq("rs_mid_num", 32'(eg.num_shift_c), 32'd2);
        rst = 1'b1;
        #1;
        chk_eq("rs_gate_shift", 32'(eg.shift_en_c), 32'd0);
        step();
        chk_eq("rs_busy", 32'(eg.busy), 32'd0);
        chk_eq("rs_valid", 32'(eg.valid), 32'd0);
        chk_eq("rs_shift_en", 32'(eg.shift_en_c), 32'd0);
        chk_eq("rs_value", eg.value, 32'd0);
        rst = 1'b0;
        step();
        dec("rs_ue0",   {16'h8000, 112'd0},                    1'b0, 0, 0, 2, 32'd1,                      1'b1, 32'd0);

        // Enable drop mid-decode aborts with no strobe
        dec("pre_en",   {16'h3C00, 112'd0},                    1'b0, 0, 0, 3, 32'({5'd3, 5'd2}),          1'b1, 32'd6);
        load({5'b00101, 123'd0});
        eg.start = 1'b1;
        step();
        eg.start = 1'b0;
        en = 1'b0;
        #1;
        chk_eq("en_gate_shift", 32'(eg.shift_en_c), 32'd0);
        step();
        chk_eq("en_busy", 32'(eg.busy), 32'd0);
        chk_eq("en_valid", 32'(eg.valid), 32'd0);
        chk_eq("en_error", 32'(eg.error), 32'd0);
        chk_eq("en_value", eg.value, 32'd0);
        en = 1'b1;
        step();
        dec("en_ue4",   {5'b00101, 123'd0},                    1'b0, 0, 0, 3, 32'({5'd3, 5'd2}),          1'b1, 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
